// File: rtl/unit_pool_scheduler_pkg.sv
// Shared types for unit_pool_scheduler: unit state, per-unit slot record, width helpers.
package unit_pool_sched_pkg;

  localparam int CNT_W        = 16;
  localparam int REQ_ID_MAX_W = 3;
  localparam int STAT_W       = 16;

  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_BUSY = 2'd1,
    U_DONE = 2'd2
  } unit_state_e;

  typedef struct packed {
    unit_state_e             state;
    logic [CNT_W-1:0]        cnt;
    logic [REQ_ID_MAX_W-1:0] req_id;
    logic                    x;
    logic                    y;
    logic                    z;
  } slot_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unit_pool_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at/after the pointer wins; pointer moves past the winner.
module rr_arbiter import unit_pool_sched_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic                         en_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic [idx_w(NUM_REQ)-1:0]    grant_idx_o
);
  localparam int RW = idx_w(NUM_REQ);

  logic [RW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  int                 sum;

  always_comb begin
    // rot[k] is requester (ptr + k) mod NUM_REQ
    rot         = NUM_REQ'({req_i, req_i} >> ptr_q);
    found       = 1'b0;
    grant_idx_o = '0;
    sum         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && en_i && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        grant_idx_o = RW'(sum);
      end
    end
    grant_o = found ? (NUM_REQ'(1) << grant_idx_o) : '0;
    ptr_d   = ptr_q;
    if (found) ptr_d = (grant_idx_o == RW'(NUM_REQ - 1)) ? '0 : grant_idx_o + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/unit_pool_scheduler.sv
// Shares NUM_UNITS single-bit compute units among NUM_REQ requesters with one response channel.
// Optional UNIT_POOL_SCHED_STATS_EN adds per-unit saturating dispatch counters (grant_cnt).
module unit_pool_scheduler import unit_pool_sched_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_UNITS = 4,
  parameter int UNIT_LAT  = 2,
  parameter int ID_BASE   = 0,
  parameter int ID_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_x,
  input  logic [NUM_REQ-1:0]         req_y,
  output logic [NUM_UNITS-1:0]       unit_x,
  output logic [NUM_UNITS-1:0]       unit_y,
  input  logic [NUM_UNITS-1:0]       unit_z,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_req_id,
  output logic [ID_W-1:0]            rsp_unit_id,
  output logic                       rsp_z
`ifdef UNIT_POOL_SCHED_STATS_EN
  ,
  output logic [NUM_UNITS*STAT_W-1:0] grant_cnt
`endif
);
  localparam int RW = idx_w(NUM_REQ);
  localparam int UW = idx_w(NUM_UNITS);

  slot_t                slot_q [NUM_UNITS];
  logic [NUM_UNITS-1:0] idle_vec, done_vec;
  logic [UW-1:0]        free_idx, first_done, rsp_idx, rsp_idx_q;
  logic [RW-1:0]        grant_idx;
  logic                 disp, rsp_fire, rsp_hold_q;

  always_comb begin
    free_idx   = '0;
    first_done = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      idle_vec[u] = (slot_q[u].state == U_IDLE);
      done_vec[u] = (slot_q[u].state == U_DONE);
      unit_x[u]   = slot_q[u].x;
      unit_y[u]   = slot_q[u].y;
      if (idle_vec[u]) free_idx   = UW'(u);
      if (done_vec[u]) first_done = UW'(u);
    end
  end

  // rst_n gates the grant so req_ready reads 0 while reset is held
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .en_i        ((|idle_vec) & rst_n),
    .grant_o     (req_ready),
    .grant_idx_o (grant_idx)
  );

  assign disp = |req_ready;

  // A stalled response keeps its unit even if a lower-index unit finishes meanwhile
  assign rsp_idx     = rsp_hold_q ? rsp_idx_q : first_done;
  assign rsp_valid   = rsp_hold_q | (|done_vec);
  assign rsp_fire    = rsp_valid & rsp_ready;
  assign rsp_req_id  = rsp_valid ? RW'(slot_q[rsp_idx].req_id) : '0;
  assign rsp_unit_id = rsp_valid ? ID_W'(ID_BASE + int'(rsp_idx)) : '0;
  assign rsp_z       = rsp_valid & slot_q[rsp_idx].z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_hold_q <= 1'b0;
      rsp_idx_q  <= '0;
    end else begin
      rsp_hold_q <= rsp_valid & ~rsp_ready;
      rsp_idx_q  <= rsp_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) slot_q[u] <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        case (slot_q[u].state)
          U_IDLE: if (disp && free_idx == UW'(u)) begin
            slot_q[u].state  <= U_BUSY;
            slot_q[u].cnt    <= CNT_W'(UNIT_LAT - 1);
            slot_q[u].req_id <= REQ_ID_MAX_W'(grant_idx);
            slot_q[u].x      <= req_x[grant_idx];
            slot_q[u].y      <= req_y[grant_idx];
          end
          U_BUSY: if (slot_q[u].cnt == '0) begin
            slot_q[u].z     <= unit_z[u];
            slot_q[u].state <= U_DONE;
          end else begin
            slot_q[u].cnt <= slot_q[u].cnt - CNT_W'(1);
          end
          U_DONE: if (rsp_fire && rsp_idx == UW'(u)) slot_q[u] <= '0;
          default: slot_q[u] <= '0;
        endcase
      end
    end
  end

`ifdef UNIT_POOL_SCHED_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_UNITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) cnt_q[u] <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++)
        if (disp && free_idx == UW'(u) && cnt_q[u] != '1) cnt_q[u] <= cnt_q[u] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_stat
    assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_unit_pool_scheduler.sv
// Bench for unit_pool_scheduler: timestamp/queue model checked every cycle plus directed literals.
module tb_unit_pool_scheduler;
  localparam int NR = 4, NU = 4, LAT = 2, IDB = 96, IDW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0, req_x = '0, req_y = '0, req_ready;
  logic [NU-1:0] unit_x, unit_y, unit_z;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_z;
  logic [1:0]    rsp_req_id;
  logic [IDW-1:0] rsp_unit_id;
`ifdef UNIT_POOL_SCHED_STATS_EN
  logic [NU*16-1:0] grant_cnt;
`endif

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign unit_z = unit_x & unit_y;

  unit_pool_scheduler #(.NUM_REQ(NR), .NUM_UNITS(NU), .UNIT_LAT(LAT), .ID_BASE(IDB), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .unit_x(unit_x), .unit_y(unit_y), .unit_z(unit_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_req_id(rsp_req_id),
    .rsp_unit_id(rsp_unit_id), .rsp_z(rsp_z)
`ifdef UNIT_POOL_SCHED_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a unit is taken at dispatch cycle d and its result is available from cycle d+LAT+1
  int m_busy [NU], m_done [NU], m_req [NU];
  logic m_x [NU], m_y [NU];
  int m_ptr, m_held, m_cyc;

  always @(negedge clk) begin
    int fu, g, p;
    logic [NR-1:0] er;
    logic [NU-1:0] ex, ey;
    if (!rst_n) begin
      for (int u = 0; u < NU; u++) m_busy[u] = 0;
      m_ptr = 0; m_held = -1; m_cyc = 0;
    end else begin
      fu = -1;
      for (int u = NU - 1; u >= 0; u--) if (m_busy[u] == 0) fu = u;
      g = -1;
      if (fu >= 0)
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      for (int u = 0; u < NU; u++) begin
        ex[u] = (m_busy[u] != 0) ? m_x[u] : 1'b0;
        ey[u] = (m_busy[u] != 0) ? m_y[u] : 1'b0;
      end
      p = m_held;
      if (p < 0)
        for (int u = NU - 1; u >= 0; u--) if (m_busy[u] != 0 && m_cyc >= m_done[u]) p = u;
      chk("model req_ready", 64'(req_ready), 64'(er));
      chk("model unit_x", 64'(unit_x), 64'(ex));
      chk("model unit_y", 64'(unit_y), 64'(ey));
      chk("model rsp_valid", 64'(rsp_valid), 64'(p >= 0));
      if (p >= 0) begin
        chk("model rsp_req_id", 64'(rsp_req_id), 64'(m_req[p]));
        chk("model rsp_unit_id", 64'(rsp_unit_id), 64'(IDB + p));
        chk("model rsp_z", 64'(rsp_z), 64'(m_x[p] & m_y[p]));
      end
      if (g >= 0) begin
        m_busy[fu] = 1; m_done[fu] = m_cyc + LAT + 1; m_req[fu] = g;
        m_x[fu] = req_x[g]; m_y[fu] = req_y[g];
        m_ptr = (g + 1) % NR;
      end
      if (p >= 0 && rsp_ready) begin
        m_busy[p] = 0; m_held = -1;
      end else begin
        m_held = p;
      end
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

    // Reset state, with requests pending to show req_ready is held low
    req_valid = 4'b1111;
    #2;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset unit_x", 64'(unit_x), 64'd0);
    chk("reset unit_y", 64'(unit_y), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_req_id", 64'(rsp_req_id), 64'd0);
    chk("reset rsp_unit_id", 64'(rsp_unit_id), 64'd0);
    chk("reset rsp_z", 64'(rsp_z), 64'd0);
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single op from requester 0
    tick();
    req_valid = 4'b0001; req_x = 4'b0001; req_y = 4'b0001; #1;
    chk("t1 req_ready", 64'(req_ready), 64'b0001);
    tick(); req_valid = '0; #1;
    chk("t1 unit_x T+1", 64'(unit_x), 64'b0001);
    chk("t1 unit_y T+1", 64'(unit_y), 64'b0001);
    tick(); #1;
    chk("t1 unit_x T+2", 64'(unit_x), 64'b0001);
    chk("t1 rsp_valid T+2", 64'(rsp_valid), 64'd0);
    tick(); #1;
    chk("t1 rsp_valid T+3", 64'(rsp_valid), 64'd1);
    chk("t1 rsp_req_id", 64'(rsp_req_id), 64'd0);
    chk("t1 rsp_unit_id", 64'(rsp_unit_id), 64'd96);
    chk("t1 rsp_z", 64'(rsp_z), 64'd1);
    tick(); #1;
    chk("t1 rsp_valid after", 64'(rsp_valid), 64'd0);
    chk("t1 unit_x idle", 64'(unit_x), 64'd0);

    // All requesters valid, responses accepted: RR order then unit 0 reused by requester 0
    do_reset();
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b1111; req_x = 4'b1011; req_y = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2 grant order", 64'(req_ready), 64'(seq[i]));
      if (i == 3) begin
        chk("t2 first rsp unit", 64'(rsp_unit_id), 64'd96);
        chk("t2 first rsp z", 64'(rsp_z), 64'd1);
      end
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    chk("t2 drained", 64'(rsp_valid), 64'd0);

    // Back-pressure: pool fills, response held stable, drain in unit order
    do_reset();
    tick();
    req_valid = 4'b1111; req_x = 4'b1111; req_y = 4'b0101;
    repeat (4) tick();
    #1;
    chk("t3 full req_ready T4", 64'(req_ready), 64'd0);
    tick(); #1;
    chk("t3 full req_ready T5", 64'(req_ready), 64'd0);
    chk("t3 stalled unit_id", 64'(rsp_unit_id), 64'd96);
    tick();
    req_valid = '0; rsp_ready = 1'b1; #1;
    chk("t3 stable unit_id", 64'(rsp_unit_id), 64'd96);
    chk("t3 stable req_id", 64'(rsp_req_id), 64'd0);
    for (int i = 1; i < 4; i++) begin
      tick(); #1;
      chk("t3 drain unit_id", 64'(rsp_unit_id), 64'(96 + i));
      chk("t3 drain req_id", 64'(rsp_req_id), 64'(i));
      chk("t3 drain z", 64'(rsp_z), 64'(i % 2 == 0));
    end
    tick(); #1;
    chk("t3 empty", 64'(rsp_valid), 64'd0);

    // Reset while two units busy
    do_reset();
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0011; req_x = 4'b0011; req_y = 4'b0011;
    tick();
    tick(); req_valid = '0; #1;
    chk("t4 busy before reset", 64'(unit_x), 64'b0011);
    rst_n = 1'b0; req_valid = 4'b1111; #1;
    chk("t4 rst req_ready", 64'(req_ready), 64'd0);
    chk("t4 rst unit_x", 64'(unit_x), 64'd0);
    chk("t4 rst unit_y", 64'(unit_y), 64'd0);
    chk("t4 rst rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1; req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("t4 no stale rsp", 64'(rsp_valid), 64'd0);
    end
    req_valid = 4'b1111; #1;
    chk("t4 pointer at 0", 64'(req_ready), 64'b0001);
    tick(); req_valid = '0; #1;
    chk("t4 lands on unit 0", 64'(unit_x), 64'b0001);
    repeat (5) tick();

`ifdef UNIT_POOL_SCHED_STATS_EN
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); req_valid = 4'b0001;
      tick(); req_valid = '0;
      repeat (4) tick();
    end
    chk("stats unit0", 64'(grant_cnt[15:0]), 64'd5);
    chk("stats others", 64'(grant_cnt[63:16]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not reach the end within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
